// File: rtl/apb_cmd_sequencer_if.sv
// ============================================================================
// Module   : apb_cmd_sequencer_if
// Brief    : Host command/response channels plus the apb_topmodule request and
//            completion signals used by apb_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;

    logic       read_write;
    logic       transfer;
    logic [7:0] apb_write_paddr;
    logic [7:0] apb_read_paddr;
    logic [7:0] apb_write_data;
    logic       pready;
    logic       pslaverr;
    logic [7:0] prdata;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               pready, pslaverr, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               read_write, transfer, apb_write_paddr, apb_read_paddr,
               apb_write_data
    );

    // Host / apb_topmodule side
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               pready, pslaverr, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               read_write, transfer, apb_write_paddr, apb_read_paddr,
               apb_write_data
    );
endinterface

`default_nettype wire

// File: rtl/apb_cmd_sequencer.sv
// ============================================================================
// Module   : apb_cmd_sequencer
// Brief    : Buffers host APB commands in a FIFO, issues them one at a time to
//            apb_topmodule and returns in-order responses. Optional WAIT-state
//            watchdog enabled by defining APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire                  pclk,
    input  wire                  preset,
    apb_cmd_sequencer_if.slave   bus,
    output logic                 busy
);

    localparam int unsigned     c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_cmd_sequencer: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [16:0]     r_mem [DEPTH];
    logic [16:0]     r_issue;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_start;
    logic            w_wait_done;
    logic            w_timeout;
    logic            w_wait_expired;
    logic            w_rsp_accept;

    logic            r_transfer;
    logic            r_read_write;
    logic [7:0]      r_write_paddr;
    logic [7:0]      r_read_paddr;
    logic [7:0]      r_write_data;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_rdata;
    logic            r_rsp_err;

    assign w_full        = (r_count == c_FULL);
    assign w_empty       = (r_count == '0);
    assign w_push        = bus.cmd_valid && !w_full;
    assign bus.cmd_ready = !w_full;
    assign busy          = (r_state != c_ST_IDLE) || !w_empty;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define valid contents
    always_ff @(posedge pclk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        if (w_pop)  r_issue         <= r_mem[r_rd_ptr];
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_start      = 1'b0;
        w_wait_done  = 1'b0;
        w_timeout    = 1'b0;
        w_rsp_accept = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty && !r_rsp_valid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A completion on the expiry cycle wins over the watchdog
                if (bus.pready) begin
                    w_wait_done = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end else if (w_wait_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_rsp_accept = 1'b1;
                    w_state_nxt  = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // APB-side request registers: loaded leaving ISSUE, cleared on completion
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset || w_wait_done || w_timeout) begin
            r_transfer    <= 1'b0;
            r_read_write  <= 1'b0;
            r_write_paddr <= '0;
            r_read_paddr  <= '0;
            r_write_data  <= '0;
        end else if (w_start) begin
            r_transfer    <= 1'b1;
            r_read_write  <= r_issue[16];
            r_write_paddr <= r_issue[16] ? r_issue[15:8] : 8'h00;
            r_read_paddr  <= r_issue[16] ? 8'h00 : r_issue[15:8];
            r_write_data  <= r_issue[16] ? r_issue[7:0] : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Response channel
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_wait_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_issue[16] ? 8'h00 : bus.prdata;
            r_rsp_err   <= bus.pslaverr;
        end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b1;
        end else if (w_rsp_accept) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned     c_TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_wait_cnt;
    logic            r_rsp_timeout;

    // Counts completed WAIT cycles; zero during the first WAIT cycle
    always_ff @(posedge pclk) begin
        if (preset || w_start)          r_wait_cnt <= '0;
        else if (r_state == c_ST_WAIT)  r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (preset || w_wait_done) r_rsp_timeout <= 1'b0;
        else if (w_timeout)        r_rsp_timeout <= 1'b1;
    end

    assign w_wait_expired  = (r_wait_cnt == c_TO_LAST);
    assign bus.rsp_timeout = r_rsp_timeout;
`else
    assign w_wait_expired  = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.transfer        = r_transfer;
    assign bus.read_write      = r_read_write;
    assign bus.apb_write_paddr = r_write_paddr;
    assign bus.apb_read_paddr  = r_read_paddr;
    assign bus.apb_write_data  = r_write_data;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.rsp_err         = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_sequencer.sv
// ============================================================================
// Module   : tb_apb_cmd_sequencer
// Brief    : Directed self-checking bench for apb_cmd_sequencer; inputs are
//            driven and outputs sampled on the falling edge of pclk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_cmd_sequencer;

    logic pclk;
    logic preset;
    logic busy;
    int   n_pass;
    int   n_total;

    apb_cmd_sequencer_if bus_if ();

    apb_cmd_sequencer #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_if),
        .busy   (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = w;
        bus_if.cmd_addr  = a;
        bus_if.cmd_wdata = d;
        @(negedge pclk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_transfer(input string tag);
        for (int k = 0; k < 20 && bus_if.transfer !== 1'b1; k++) @(negedge pclk);
        chk({tag, "_xfer"}, bus_if.transfer, 1'b1);
    endtask

    // Completes one transfer: pready after 'waits' extra WAIT cycles, then handshake
    task automatic serve(input string tag, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] pd, input logic se,
                         input int waits);
        wait_transfer(tag);
        chk({tag, "_rw"},     bus_if.read_write,      w);
        chk({tag, "_wpaddr"}, bus_if.apb_write_paddr, w ? a : 8'h00);
        chk({tag, "_rpaddr"}, bus_if.apb_read_paddr,  w ? 8'h00 : a);
        chk({tag, "_wdata"},  bus_if.apb_write_data,  w ? d : 8'h00);
        repeat (waits) begin
            @(negedge pclk);
            chk({tag, "_hold"}, bus_if.transfer, 1'b1);
        end
        bus_if.pready   = 1'b1;
        bus_if.prdata   = pd;
        bus_if.pslaverr = se;
        @(negedge pclk);
        bus_if.pready   = 1'b0;
        bus_if.pslaverr = 1'b0;
        chk({tag, "_drop"},    bus_if.transfer,    1'b0);
        chk({tag, "_rvalid"},  bus_if.rsp_valid,   1'b1);
        chk({tag, "_rdata"},   bus_if.rsp_rdata,   w ? 8'h00 : pd);
        chk({tag, "_err"},     bus_if.rsp_err,     se);
        chk({tag, "_timeout"}, bus_if.rsp_timeout, 1'b0);
        bus_if.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_if.rsp_ready = 1'b0;
        chk({tag, "_rclear"}, bus_if.rsp_valid, 1'b0);
    endtask

    logic       w3  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] a3  [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    logic [7:0] d3  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] pd3 [5] = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95};

    initial begin
        n_pass           = 0;
        n_total          = 0;
        preset           = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 8'h00;
        bus_if.cmd_wdata = 8'h00;
        bus_if.rsp_ready = 1'b0;
        bus_if.pready    = 1'b0;
        bus_if.pslaverr  = 1'b0;
        bus_if.prdata    = 8'h00;
        repeat (3) @(negedge pclk);
        preset = 1'b0;

        // Reset state
        chk("rst_cmd_ready", bus_if.cmd_ready,       1'b1);
        chk("rst_transfer",  bus_if.transfer,        1'b0);
        chk("rst_rw",        bus_if.read_write,      1'b0);
        chk("rst_wpaddr",    bus_if.apb_write_paddr, 8'h00);
        chk("rst_rvalid",    bus_if.rsp_valid,       1'b0);
        chk("rst_rdata",     bus_if.rsp_rdata,       8'h00);
        chk("rst_err",       bus_if.rsp_err,         1'b0);
        chk("rst_timeout",   bus_if.rsp_timeout,     1'b0);
        chk("rst_busy",      busy,                   1'b0);

        // 1: write 05/A5, transfer rises two edges after acceptance, 2 extra WAIT cycles
        push(1'b1, 8'h05, 8'hA5);
        chk("t1_lat1", bus_if.transfer, 1'b0);
        chk("t1_busy", busy,            1'b1);
        @(negedge pclk);
        chk("t1_lat2", bus_if.transfer, 1'b0);
        @(negedge pclk);
        chk("t1_lat3", bus_if.transfer, 1'b1);
        serve("t1", 1'b1, 8'h05, 8'hA5, 8'h77, 1'b0, 2);
        chk("t1_idle", busy, 1'b0);

        // 2: read 05 returning A5; write data must read back 0
        push(1'b0, 8'h05, 8'hCC);
        serve("t2", 1'b0, 8'h05, 8'hCC, 8'hA5, 1'b0, 0);

        // 4: pready/pslaverr during ISSUE ignored, then slave error in WAIT
        push(1'b0, 8'h44, 8'h00);
        @(negedge pclk);
        bus_if.pready   = 1'b1;
        bus_if.pslaverr = 1'b1;
        bus_if.prdata   = 8'hEE;
        @(negedge pclk);
        bus_if.pready   = 1'b0;
        bus_if.pslaverr = 1'b0;
        chk("t4_issue_rvalid", bus_if.rsp_valid, 1'b0);
        chk("t4_issue_xfer",   bus_if.transfer,  1'b1);
        serve("t4", 1'b0, 8'h44, 8'h00, 8'h3C, 1'b1, 0);

        // 3: five back-to-back pushes fill a 4-deep FIFO (one already popped)
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready", bus_if.cmd_ready, 1'b1);
            bus_if.cmd_valid = 1'b1;
            bus_if.cmd_write = w3[i];
            bus_if.cmd_addr  = a3[i];
            bus_if.cmd_wdata = d3[i];
            @(negedge pclk);
        end
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 8'hEE;
        bus_if.cmd_wdata = 8'hFF;
        chk("t3_full", bus_if.cmd_ready, 1'b0);
        repeat (2) @(negedge pclk);
        bus_if.cmd_valid = 1'b0;
        chk("t3_full_hold", bus_if.cmd_ready, 1'b0);
        for (int i = 0; i < 5; i++) serve("t3", w3[i], a3[i], d3[i], pd3[i], 1'b0, i % 2);
        chk("t3_drained", busy, 1'b0);
        repeat (4) @(negedge pclk);
        chk("t3_no_extra", bus_if.transfer, 1'b0);

        // 5: response back-pressure with a second command queued
        push(1'b0, 8'h60, 8'h00);
        push(1'b1, 8'h70, 8'h71);
        wait_transfer("t5a");
        chk("t5a_rpaddr", bus_if.apb_read_paddr, 8'h60);
        bus_if.pready = 1'b1;
        bus_if.prdata = 8'h66;
        @(negedge pclk);
        bus_if.pready = 1'b0;
        bus_if.prdata = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("t5_rvalid", bus_if.rsp_valid, 1'b1);
            chk("t5_rdata",  bus_if.rsp_rdata, 8'h66);
            chk("t5_noxfer", bus_if.transfer,  1'b0);
            @(negedge pclk);
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_if.rsp_ready = 1'b0;
        chk("t5_rclear", bus_if.rsp_valid, 1'b0);
        serve("t5b", 1'b1, 8'h70, 8'h71, 8'h00, 1'b0, 0);

        // 6: reset in WAIT drops the transfer and flushes the queue
        push(1'b1, 8'h80, 8'h81);
        push(1'b0, 8'h82, 8'h00);
        wait_transfer("t6");
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        chk("t6_transfer",  bus_if.transfer,        1'b0);
        chk("t6_rvalid",    bus_if.rsp_valid,       1'b0);
        chk("t6_busy",      busy,                   1'b0);
        chk("t6_cmd_ready", bus_if.cmd_ready,       1'b1);
        chk("t6_wpaddr",    bus_if.apb_write_paddr, 8'h00);
        repeat (5) @(negedge pclk);
        chk("t6_quiet_xfer", bus_if.transfer, 1'b0);
        chk("t6_quiet_busy", busy,            1'b0);

`ifdef APB_TIMEOUT_EN
        // Watchdog: 16 WAIT cycles without pready
        push(1'b0, 8'h90, 8'h00);
        wait_transfer("to");
        repeat (15) begin
            @(negedge pclk);
            chk("to_hold", bus_if.transfer, 1'b1);
        end
        @(negedge pclk);
        chk("to_drop",    bus_if.transfer,    1'b0);
        chk("to_rvalid",  bus_if.rsp_valid,   1'b1);
        chk("to_err",     bus_if.rsp_err,     1'b1);
        chk("to_timeout", bus_if.rsp_timeout, 1'b1);
        chk("to_rdata",   bus_if.rsp_rdata,   8'h00);
        bus_if.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_if.rsp_ready = 1'b0;

        // pready on the expiry cycle gives a normal response
        push(1'b0, 8'h92, 8'h00);
        wait_transfer("tp");
        repeat (15) @(negedge pclk);
        bus_if.pready = 1'b1;
        bus_if.prdata = 8'h5A;
        @(negedge pclk);
        bus_if.pready = 1'b0;
        chk("tp_rvalid",  bus_if.rsp_valid,   1'b1);
        chk("tp_timeout", bus_if.rsp_timeout, 1'b0);
        chk("tp_err",     bus_if.rsp_err,     1'b0);
        chk("tp_rdata",   bus_if.rsp_rdata,   8'h5A);
        bus_if.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_if.rsp_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
